// File: rtl/vram_arbiter.sv
// Shares one single-port 160x120x3 VRAM between VGA display fetch (owns every D-slot it needs) and a 4-deep host write queue.
// Zero-offset pixel path; oHostReady drops while the queue is full. VRAM_BLANK_ONLY_EN restricts host writes to vertical blanking.
module vram_arbiter (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [9:0]  iColumn,
  input  logic [9:0]  iRow,
  input  logic        iHostValid,
  input  logic [14:0] iHostAddr,
  input  logic [2:0]  iHostData,
  output logic        oHostReady,
  output logic        oHostDone,
  output logic        oHostError,
  output logic [14:0] oRamAddr,
  output logic        oRamWriteEnable,
  output logic [2:0]  oRamData,
  input  logic [2:0]  iRamData,
  output logic [2:0]  oPixel
);

  localparam logic [14:0] FB_ENTRIES = 15'd19200;
  localparam logic [9:0]  H_VISIBLE  = 10'd640;
  localparam logic [9:0]  V_VISIBLE  = 10'd480;
  localparam logic [9:0]  H_LAST     = 10'd799;
  localparam logic [9:0]  V_LAST     = 10'd524;
  localparam logic [2:0]  FIFO_DEPTH = 3'd4;

  typedef struct packed {
    logic [14:0] addr;
    logic [2:0]  data;
  } host_wr_t;

  // 160 = 128 + 32, so the multiply reduces to two shifts and an add.
  function automatic logic [14:0] fb_index(input logic [9:0] row, input logic [9:0] col);
    logic [14:0] blk_row;
    blk_row = {7'd0, row[9:2]};
    return (blk_row << 7) + (blk_row << 5) + {7'd0, col[9:2]};
  endfunction

  logic [9:0] col_q;
  logic       fetch_q;
  logic [2:0] pix_q, pix_d;
  host_wr_t   fifo_q [4];
  logic [1:0] wr_ptr_q, wr_ptr_d;
  logic [1:0] rd_ptr_q, rd_ptr_d;
  logic [2:0] count_q, count_d;

  logic       d_slot;
  logic       fetch_now;
  logic [9:0] fetch_row;
  logic [9:0] fetch_col;
  logic       host_window;
  logic       push;
  logic       grant;
  logic       head_ok;
  host_wr_t   head;

  assign d_slot = Reset && (iColumn != col_q);

  // Fetch one column ahead so the data lands in pix_q exactly when iColumn reaches it.
  always_comb begin
    fetch_now = 1'b0;
    fetch_row = '0;
    fetch_col = '0;
    if (d_slot) begin
      if ((iColumn < (H_VISIBLE - 10'd1)) && (iRow < V_VISIBLE)) begin
        fetch_now = 1'b1;
        fetch_row = iRow;
        fetch_col = iColumn + 10'd1;
      end else if ((iColumn == H_LAST) && (iRow < (V_VISIBLE - 10'd1))) begin
        fetch_now = 1'b1;
        fetch_row = iRow + 10'd1;
      end else if ((iColumn == H_LAST) && (iRow == V_LAST)) begin
        fetch_now = 1'b1;
      end
    end
  end

`ifdef VRAM_BLANK_ONLY_EN
  assign host_window = (iRow >= V_VISIBLE);
`else
  assign host_window = 1'b1;
`endif

  assign head       = fifo_q[rd_ptr_q];
  assign head_ok    = (head.addr < FB_ENTRIES);
  assign oHostReady = Reset && (count_q != FIFO_DEPTH);
  assign push       = iHostValid && oHostReady;
  assign grant      = Reset && !fetch_now && (count_q != 3'd0) && host_window;

  always_comb begin
    oRamAddr        = '0;
    oRamData        = '0;
    oRamWriteEnable = 1'b0;
    oHostDone       = 1'b0;
    oHostError      = 1'b0;
    if (fetch_now) begin
      oRamAddr = fb_index(fetch_row, fetch_col);
    end else if (grant) begin
      if (head_ok) begin
        oRamAddr        = head.addr;
        oRamData        = head.data;
        oRamWriteEnable = 1'b1;
        oHostDone       = 1'b1;
      end else begin
        oHostError = 1'b1;
      end
    end
  end

  always_comb begin
    pix_d    = fetch_q ? iRamData : pix_q;
    wr_ptr_d = push  ? wr_ptr_q + 2'd1 : wr_ptr_q;
    rd_ptr_d = grant ? rd_ptr_q + 2'd1 : rd_ptr_q;
    count_d  = count_q + {2'd0, push} - {2'd0, grant};
  end

  assign oPixel = (Reset && (iColumn < H_VISIBLE) && (iRow < V_VISIBLE)) ? pix_q : 3'b000;

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      col_q    <= '0;
      fetch_q  <= 1'b0;
      pix_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      col_q    <= iColumn;
      fetch_q  <= fetch_now;
      pix_q    <= pix_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge Clock) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= '{addr: iHostAddr, data: iHostData};
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: vector table for slot/fetch decisions plus hand-written multi-cycle sequences.
module tb_vram_arbiter;

  logic        clk = 1'b0;
  logic        Reset;
  logic [9:0]  iColumn;
  logic [9:0]  iRow;
  logic        iHostValid;
  logic [14:0] iHostAddr;
  logic [2:0]  iHostData;
  logic        oHostReady;
  logic        oHostDone;
  logic        oHostError;
  logic [14:0] oRamAddr;
  logic        oRamWriteEnable;
  logic [2:0]  oRamData;
  logic [2:0]  iRamData;
  logic [2:0]  oPixel;

  always #5 clk = ~clk;

  vram_arbiter dut (
    .Clock(clk), .Reset(Reset), .iColumn(iColumn), .iRow(iRow),
    .iHostValid(iHostValid), .iHostAddr(iHostAddr), .iHostData(iHostData),
    .oHostReady(oHostReady), .oHostDone(oHostDone), .oHostError(oHostError),
    .oRamAddr(oRamAddr), .oRamWriteEnable(oRamWriteEnable), .oRamData(oRamData),
    .iRamData(iRamData), .oPixel(oPixel)
  );

  // VRAM model: one-cycle read latency, plus a bench-side preload port.
  logic [2:0]  vram [0:32767];
  logic [2:0]  ram_rd_q;
  logic        tb_we;
  logic [14:0] tb_addr;
  logic [2:0]  tb_dat;

  always @(posedge clk) begin
    if (tb_we) vram[tb_addr] <= tb_dat;
    else if (oRamWriteEnable) vram[oRamAddr] <= oRamData;
    ram_rd_q <= vram[oRamAddr];
  end
  assign iRamData = ram_rd_q;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  function automatic logic host_window(input logic [9:0] row);
`ifdef VRAM_BLANK_ONLY_EN
    return row >= 10'd480;
`else
    return (row == row);
`endif
  endfunction

  typedef struct {
    logic [9:0]  prev_col;
    logic [9:0]  col;
    logic [9:0]  row;
    logic        fetch;
    logic [14:0] addr;
  } vec_t;

  vec_t       vecs [12];
  logic [2:0] pix_exp [3];

  initial begin
    vecs[0]  = '{10'd10,  10'd11,  10'd0,   1'b1, 15'd3};
    vecs[1]  = '{10'd637, 10'd638, 10'd479, 1'b1, 15'd19199};
    vecs[2]  = '{10'd638, 10'd639, 10'd100, 1'b0, 15'd0};
    vecs[3]  = '{10'd798, 10'd799, 10'd2,   1'b1, 15'd0};
    vecs[4]  = '{10'd798, 10'd799, 10'd478, 1'b1, 15'd19040};
    vecs[5]  = '{10'd798, 10'd799, 10'd479, 1'b0, 15'd0};
    vecs[6]  = '{10'd798, 10'd799, 10'd524, 1'b1, 15'd0};
    vecs[7]  = '{10'd700, 10'd701, 10'd10,  1'b0, 15'd0};
    vecs[8]  = '{10'd5,   10'd6,   10'd500, 1'b0, 15'd0};
    vecs[9]  = '{10'd100, 10'd101, 10'd7,   1'b1, 15'd185};
    vecs[10] = '{10'd798, 10'd799, 10'd523, 1'b0, 15'd0};
    vecs[11] = '{10'd400, 10'd401, 10'd300, 1'b1, 15'd12100};
    pix_exp[0] = 3'b100;
    pix_exp[1] = 3'b010;
    pix_exp[2] = 3'b001;

    // Reset held with busy-looking inputs; VRAM preloaded meanwhile.
    Reset = 1'b0; iColumn = 10'd5; iRow = 10'd0;
    iHostValid = 1'b1; iHostAddr = 15'd1; iHostData = 3'd7;
    tb_we = 1'b0; tb_addr = '0; tb_dat = '0;
    for (int i = 0; i < 3; i++) begin
      tb_we = 1'b1; tb_addr = 15'(i); tb_dat = pix_exp[i];
      settle();
      chk("rst_ready", oHostReady, 0);
      chk("rst_we", oRamWriteEnable, 0);
      chk("rst_addr", oRamAddr, 0);
      chk("rst_data", oRamData, 0);
      chk("rst_done", oHostDone, 0);
      chk("rst_err", oHostError, 0);
      chk("rst_pix", oPixel, 0);
      tick();
    end
    tb_we = 1'b0; Reset = 1'b1; iHostValid = 1'b0; iColumn = 10'd0;
    settle();
    chk("post_rst_ready", oHostReady, 1);
    chk("post_rst_we", oRamWriteEnable, 0);
    tick();

    // Frame wrap fetch at (524,799) then zero-offset pixels across row 0.
    iRow = 10'd524; iColumn = 10'd798; tick(); tick();
    iColumn = 10'd799; tick(); tick();
    iRow = 10'd0;
    for (int c = 0; c < 12; c++) begin
      iColumn = 10'(c);
      settle(); chk("pix_d_slot", oPixel, pix_exp[c / 4]); tick();
      settle(); chk("pix_h_slot", oPixel, pix_exp[c / 4]); tick();
    end

`ifndef VRAM_BLANK_ONLY_EN
    // Five back-to-back writes while every cycle is a fetching D-slot.
    iHostValid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      iColumn = 10'(20 + i); iHostAddr = 15'(300 + i); iHostData = 3'(i + 1);
      settle();
      chk("fill_ready", oHostReady, (i < 4) ? 1 : 0);
      chk("fill_we", oRamWriteEnable, 0);
      tick();
    end
    for (int j = 0; j < 5; j++) begin
      iColumn = 10'(25 + j);
      settle();
      chk("drain_d_we", oRamWriteEnable, 0);
      chk("drain_d_done", oHostDone, 0);
      if (j == 0) chk("drain_full_ready", oHostReady, 0);
      if (j == 1) chk("drain_room_ready", oHostReady, 1);
      tick();
      if (j == 1) iHostValid = 1'b0;
      settle();
      chk("drain_h_we", oRamWriteEnable, 1);
      chk("drain_h_addr", oRamAddr, 300 + j);
      chk("drain_h_data", oRamData, j + 1);
      chk("drain_h_done", oHostDone, 1);
      tick();
    end

    // Out-of-range write is discarded with an error, the next one commits.
    iHostValid = 1'b1; iHostAddr = 15'd19200; iHostData = 3'd7; iColumn = 10'd40;
    settle(); chk("oor_push_err", oHostError, 0); tick();
    iHostAddr = 15'd5; iHostData = 3'd6; iColumn = 10'd41;
    settle(); chk("oor_push_we", oRamWriteEnable, 0); tick();
    iHostValid = 1'b0;
    settle();
    chk("oor_err", oHostError, 1);
    chk("oor_we", oRamWriteEnable, 0);
    chk("oor_done", oHostDone, 0);
    tick();
    settle();
    chk("ok_we", oRamWriteEnable, 1);
    chk("ok_addr", oRamAddr, 5);
    chk("ok_data", oRamData, 6);
    chk("ok_done", oHostDone, 1);
    chk("ok_err", oHostError, 0);
    tick();
    settle(); chk("idle_we", oRamWriteEnable, 0); tick();
`endif

    // Vector table: one pending host write competes with each D-slot decision.
    for (int i = 0; i < 12; i++) begin
      logic exp_we;
      iRow = vecs[i].row; iColumn = vecs[i].prev_col;
      iHostValid = 1'b1; iHostAddr = 15'(9000 + i); iHostData = 3'(i);
      tick();
      iColumn = vecs[i].col; iHostValid = 1'b0;
      exp_we = !vecs[i].fetch && host_window(vecs[i].row);
      settle();
      chk($sformatf("vec%0d_we", i), oRamWriteEnable, exp_we);
      chk($sformatf("vec%0d_addr", i), oRamAddr,
          vecs[i].fetch ? vecs[i].addr : (exp_we ? 15'(9000 + i) : 15'd0));
      if (vecs[i].col >= 10'd640 || vecs[i].row >= 10'd480)
        chk($sformatf("vec%0d_blank_pix", i), oPixel, 0);
      tick();
      iRow = 10'd500;
      tick(); tick();
    end

    // Single write pushed mid-frame at row 100.
    iRow = 10'd100; iHostValid = 1'b1; iHostAddr = 15'd777; iHostData = 3'd3;
    tick();
    iHostValid = 1'b0;
`ifdef VRAM_BLANK_ONLY_EN
    for (int i = 0; i < 4; i++) begin
      settle(); chk("blank_hold_we", oRamWriteEnable, 0); tick();
    end
    iRow = 10'd480;
`endif
    settle();
    chk("row100_we", oRamWriteEnable, 1);
    chk("row100_addr", oRamAddr, 777);
    chk("row100_done", oHostDone, 1);
    tick();

    // Reset with three writes queued behind continuous fetches.
    iRow = 10'd0; iHostValid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      iColumn = 10'(100 + i); iHostAddr = 15'(400 + i); iHostData = 3'(i + 2);
      settle();
      chk("q3_ready", oHostReady, 1);
      chk("q3_we", oRamWriteEnable, 0);
      tick();
    end
    iHostValid = 1'b0; Reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      iColumn = 10'(103 + i);
      settle();
      chk("mid_rst_we", oRamWriteEnable, 0);
      chk("mid_rst_done", oHostDone, 0);
      chk("mid_rst_ready", oHostReady, 0);
      chk("mid_rst_addr", oRamAddr, 0);
      chk("mid_rst_pix", oPixel, 0);
      tick();
    end
    Reset = 1'b1; iColumn = 10'd0; iRow = 10'd500;
    for (int i = 0; i < 6; i++) begin
      settle();
      chk("after_rst_we", oRamWriteEnable, 0);
      chk("after_rst_done", oHostDone, 0);
      chk("after_rst_ready", oHostReady, 1);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
